// File: rtl/fact_bus_master.sv
// Bus initiator for the factorial accelerator: programs the operand, launches the core, waits
// for completion, reads the 128-bit result, clears the core and stores the result to memory.
module fact_bus_master #(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter bit          USE_POLL  = 1'b0,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [63:0]  operand,
  input  logic [15:0]  dest_addr,
  input  logic         m_grant,
  input  logic [63:0]  m_din,
  input  logic         interrupt,
  output logic         m_req,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result
);

  localparam logic [15:0] AddrStart   = BASE_ADDR + 16'h0000;
  localparam logic [15:0] AddrClear   = BASE_ADDR + 16'h0008;
  localparam logic [15:0] AddrOpDone  = BASE_ADDR + 16'h0010;
  localparam logic [15:0] AddrIntrEn  = BASE_ADDR + 16'h0018;
  localparam logic [15:0] AddrOperand = BASE_ADDR + 16'h0020;
  localparam logic [15:0] AddrResH    = BASE_ADDR + 16'h0028;
  localparam logic [15:0] AddrResL    = BASE_ADDR + 16'h0030;

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StReq, StWOpnd, StWInten, StWStart, StWait, StRResH, StRResL,
    StWClr1, StWClr0, StWMemLo, StWMemHi, StRel, StAClr1, StAClr0, StAbort
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] data;
  } bus_t;

  state_e         state_q;
  bus_t           bus_q;
  logic [63:0]    opnd_q;
  logic [15:0]    dest_q;
  logic [CntW-1:0] cnt_q;
  logic           req_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic [127:0]   result_q;

  logic wait_hit;
  assign wait_hit = USE_POLL ? m_din[0] : interrupt;

  // Bus cycle presented while the FSM sits in state s; registered on entry to s.
  function automatic bus_t bus_for(input state_e s);
    bus_t b;
    b = '0;
    case (s)
      StWOpnd:           b = '{wr: 1'b1, addr: AddrOperand, data: opnd_q};
      StWInten:          b = '{wr: 1'b1, addr: AddrIntrEn, data: USE_POLL ? 64'd0 : 64'd1};
      StWStart:          b = '{wr: 1'b1, addr: AddrStart, data: 64'd1};
      StWait:            b = '{wr: 1'b0, addr: AddrOpDone, data: 64'd0};
      StRResH:           b = '{wr: 1'b0, addr: AddrResH, data: 64'd0};
      StRResL:           b = '{wr: 1'b0, addr: AddrResL, data: 64'd0};
      StWClr1, StAClr1:  b = '{wr: 1'b1, addr: AddrClear, data: 64'd1};
      StWClr0, StAClr0:  b = '{wr: 1'b1, addr: AddrClear, data: 64'd0};
      StWMemLo:          b = '{wr: 1'b1, addr: dest_q, data: result_q[63:0]};
      StWMemHi:          b = '{wr: 1'b1, addr: dest_q + 16'd1, data: result_q[127:64]};
      default:           b = '0;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      bus_q    <= '0;
      opnd_q   <= '0;
      dest_q   <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      // Every state past StReq advances only on a granted cycle; a lost grant freezes it.
      unique case (state_q)
        StIdle: begin
          if (start) begin
            opnd_q  <= operand;
            dest_q  <= dest_addr;
            busy_q  <= 1'b1;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (m_grant) begin
            state_q <= StWOpnd;
            bus_q   <= bus_for(StWOpnd);
          end
        end
        StWOpnd: begin
          if (m_grant) begin
            state_q <= StWInten;
            bus_q   <= bus_for(StWInten);
          end
        end
        StWInten: begin
          if (m_grant) begin
            state_q <= StWStart;
            bus_q   <= bus_for(StWStart);
          end
        end
        StWStart: begin
          if (m_grant) begin
            state_q <= StWait;
            bus_q   <= bus_for(StWait);
            cnt_q   <= '0;
          end
        end
        StWait: begin
          if (m_grant) begin
            if (wait_hit) begin
              state_q <= StRResH;
              bus_q   <= bus_for(StRResH);
            end else if (cnt_q == CntLast) begin
              state_q <= StAClr1;
              bus_q   <= bus_for(StAClr1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StRResH: begin
          if (m_grant) begin
            result_q[127:64] <= m_din;
            state_q          <= StRResL;
            bus_q            <= bus_for(StRResL);
          end
        end
        StRResL: begin
          if (m_grant) begin
            result_q[63:0] <= m_din;
            state_q        <= StWClr1;
            bus_q          <= bus_for(StWClr1);
          end
        end
        StWClr1: begin
          if (m_grant) begin
            state_q <= StWClr0;
            bus_q   <= bus_for(StWClr0);
          end
        end
        StWClr0: begin
          if (m_grant) begin
            state_q <= StWMemLo;
            bus_q   <= bus_for(StWMemLo);
          end
        end
        StWMemLo: begin
          if (m_grant) begin
            state_q <= StWMemHi;
            bus_q   <= bus_for(StWMemHi);
          end
        end
        StWMemHi: begin
          if (m_grant) begin
            state_q <= StRel;
            bus_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StRel: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StAClr1: begin
          if (m_grant) begin
            state_q <= StAClr0;
            bus_q   <= bus_for(StAClr0);
          end
        end
        StAClr0: begin
          if (m_grant) begin
            state_q <= StAbort;
            bus_q   <= '0;
            req_q   <= 1'b0;
            error_q <= 1'b1;
          end
        end
        StAbort: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_req  = req_q;
  assign m_wr   = bus_q.wr & m_grant;
  assign m_addr = bus_q.addr;
  assign m_dout = bus_q.data;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_fact_bus_master.sv
// Bench for fact_bus_master: one interrupt-driven and one polling instance, each driving a
// behavioural accelerator, arbiter and write logger.
module tb_fact_bus_master;

  localparam int unsigned Tmo = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   start = '0;
  logic [63:0]  operand [2];
  logic [15:0]  dest [2];
  logic [1:0]   m_grant, intr, m_req, m_wr, busy, done, error;
  logic [63:0]  m_din [2];
  logic [63:0]  m_dout [2];
  logic [15:0]  m_addr [2];
  logic [127:0] result [2];

  always #5 clk = ~clk;

  fact_bus_master #(.BASE_ADDR(16'h7000), .USE_POLL(1'b0), .TIMEOUT(Tmo)) u_dut_irq (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .operand(operand[0]),
    .dest_addr(dest[0]), .m_grant(m_grant[0]), .m_din(m_din[0]), .interrupt(intr[0]),
    .m_req(m_req[0]), .m_wr(m_wr[0]), .m_addr(m_addr[0]), .m_dout(m_dout[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .result(result[0])
  );

  fact_bus_master #(.BASE_ADDR(16'h7000), .USE_POLL(1'b1), .TIMEOUT(Tmo)) u_dut_poll (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .operand(operand[1]),
    .dest_addr(dest[1]), .m_grant(m_grant[1]), .m_din(m_din[1]), .interrupt(intr[1]),
    .m_req(m_req[1]), .m_wr(m_wr[1]), .m_addr(m_addr[1]), .m_dout(m_dout[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .result(result[1])
  );

  // Behavioural accelerator, arbiter and bus monitors
  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t          wlog[$];
  logic [63:0]  acc_op [2];
  logic [127:0] acc_res [2];
  logic [1:0]   acc_ien = '0, acc_done = '0, acc_busy = '0, intr_kill = '0, gnt_block = '0;
  logic [1:0]   req_seen = '0;
  int           acc_cnt [2] = '{0, 0};
  int           acc_lat [2] = '{1, 1};
  int           gnt_delay [2] = '{0, 0};
  int           gcnt [2] = '{0, 0};
  int           nogrant_viol [2] = '{0, 0};
  int           early_drop [2] = '{0, 0};
  int           done_cnt [2] = '{0, 0};
  int           err_cnt [2] = '{0, 0};
  int           poll_reads [2] = '{0, 0};

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (int k = 2; k <= 40 && 64'(k) <= n; k++) r = r * 128'(k);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_bus
    assign m_grant[g] = m_req[g] && (gcnt[g] >= gnt_delay[g]) && !gnt_block[g];
    assign intr[g]    = acc_done[g] & acc_ien[g] & ~intr_kill[g];
    assign m_din[g]   = (m_addr[g] == 16'h7010) ? {62'd0, acc_busy[g], acc_done[g]} :
                        (m_addr[g] == 16'h7028) ? acc_res[g][127:64] :
                        (m_addr[g] == 16'h7030) ? acc_res[g][63:0] :
                        (m_addr[g] == 16'h7020) ? acc_op[g] : 64'd0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!m_req[i]) gcnt[i] <= 0;
      else if (gcnt[i] < 100000) gcnt[i] <= gcnt[i] + 1;
      if (!m_grant[i] && m_wr[i]) nogrant_viol[i] <= nogrant_viol[i] + 1;
      if (busy[i] && req_seen[i] && !m_req[i] && !done[i] && !error[i])
        early_drop[i] <= early_drop[i] + 1;
      req_seen[i] <= busy[i] && (req_seen[i] || m_req[i]);
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (error[i]) err_cnt[i] <= err_cnt[i] + 1;
      if (m_req[i] && m_grant[i] && !m_wr[i] && m_addr[i] == 16'h7010)
        poll_reads[i] <= poll_reads[i] + 1;
      if (acc_busy[i]) begin
        if (acc_cnt[i] <= 1) begin
          acc_busy[i] <= 1'b0;
          acc_done[i] <= 1'b1;
          acc_res[i]  <= fact(acc_op[i]);
        end else begin
          acc_cnt[i] <= acc_cnt[i] - 1;
        end
      end
      if (m_wr[i]) begin
        wlog.push_back('{i, m_addr[i], m_dout[i]});
        case (m_addr[i])
          16'h7020: acc_op[i] <= m_dout[i];
          16'h7018: acc_ien[i] <= m_dout[i][0];
          16'h7000: begin
            if (m_dout[i][0]) begin
              if (acc_lat[i] == 0) begin
                acc_done[i] <= 1'b1;
                acc_res[i]  <= fact(acc_op[i]);
              end else begin
                acc_done[i] <= 1'b0;
                acc_busy[i] <= 1'b1;
                acc_cnt[i]  <= acc_lat[i];
              end
            end
          end
          16'h7008: begin
            if (m_dout[i][0]) begin
              acc_done[i] <= 1'b0;
              acc_busy[i] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Checking
  typedef struct {
    int           idx;
    logic [127:0] res;
  } sb_t;

  typedef struct {
    int           idx;
    logic [63:0]  op;
    logic [15:0]  dst;
    int           gd;
    int           lat;
    logic [127:0] exp;
  } vec_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_log(input int n, input logic [15:0] ea[7], input logic [63:0] ed[7]);
    check("write count", 128'(wlog.size()), 128'(n));
    for (int k = 0; k < n && k < wlog.size(); k++) begin
      check($sformatf("write %0d addr", k), 128'(wlog[k].addr), 128'(ea[k]));
      check($sformatf("write %0d data", k), 128'(wlog[k].data), 128'(ed[k]));
    end
  endtask

  task automatic launch(input int i, input logic [63:0] op, input logic [15:0] dst);
    @(negedge clk);
    start[i]   = 1'b1;
    operand[i] = op;
    dest[i]    = dst;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  // cyc counts the start cycle as 1 and the cycle showing done/error as the last.
  task automatic wait_end(input int i, output int cyc, output bit got_done, output bit got_err);
    cyc = 1;
    got_done = 1'b0;
    got_err = 1'b0;
    while (!got_done && !got_err && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      got_done = done[i];
      got_err  = error[i];
    end
  endtask

  task automatic run_txn(input int i, input logic [63:0] op, input logic [15:0] dst,
                         input int gd, input int lat, input logic [127:0] exp, output int cyc);
    bit           gdn, ger;
    int           d0;
    sb_t          e;
    logic [15:0]  ea[7];
    logic [63:0]  ed[7];
    logic [15:0]  hi_a;
    gnt_delay[i] = gd;
    acc_lat[i]   = lat;
    wlog.delete();
    d0 = done_cnt[i];
    sb.push_back('{i, exp});
    launch(i, op, dst);
    wait_end(i, cyc, gdn, ger);
    check("done seen", 128'(gdn), 128'd1);
    check("no error", 128'(ger), 128'd0);
    if (gdn && sb.size() > 0) begin
      e = sb.pop_front();
      check("result", result[i], e.res);
    end
    hi_a = dst + 16'd1;
    ea = '{16'h7020, 16'h7018, 16'h7000, 16'h7008, 16'h7008, dst, hi_a};
    ed = '{op, (i == 0) ? 64'd1 : 64'd0, 64'd1, 64'd1, 64'd0, exp[63:0], exp[127:64]};
    check_log(7, ea, ed);
    @(negedge clk);
    check("m_req after", 128'(m_req[i]), 128'd0);
    check("busy after", 128'(busy[i]), 128'd0);
    check("done pulses", 128'(done_cnt[i] - d0), 128'd1);
  endtask

  vec_t vt[5];

  initial begin
    int           cyc, k, p0, e0, d0;
    bit           gdn, ger;
    logic [127:0] r0;
    logic [15:0]  ea[7];
    logic [63:0]  ed[7];

    vt[0] = '{0, 64'd5,  16'h0070, 1, 3, 128'd120};
    vt[1] = '{1, 64'd10, 16'h00FE, 0, 4, 128'd3628800};
    vt[2] = '{0, 64'd0,  16'h0100, 0, 2, 128'd1};
    vt[3] = '{1, 64'd20, 16'h0200, 2, 2, 128'd2432902008176640000};
    vt[4] = '{0, 64'd25, 16'hFFFF, 0, 1, 128'd15511210043330985984000000};

    for (int i = 0; i < 2; i++) begin
      operand[i] = '0;
      dest[i]    = '0;
      acc_op[i]  = '0;
      acc_res[i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst m_req", 128'(m_req[i]), 128'd0);
      check("rst m_wr", 128'(m_wr[i]), 128'd0);
      check("rst m_addr", 128'(m_addr[i]), 128'd0);
      check("rst m_dout", 128'(m_dout[i]), 128'd0);
      check("rst busy", 128'(busy[i]), 128'd0);
      check("rst done", 128'(done[i]), 128'd0);
      check("rst error", 128'(error[i]), 128'd0);
      check("rst result", result[i], 128'd0);
    end
    reset_n = 1'b1;

    // Immediate grant and interrupt in the first wait cycle
    run_txn(0, 64'd3, 16'h0300, 0, 0, 128'd6, cyc);
    check("min latency", 128'(cyc), 128'd13);

    for (int v = 0; v < 5; v++) begin
      p0 = poll_reads[1];
      run_txn(vt[v].idx, vt[v].op, vt[v].dst, vt[v].gd, vt[v].lat, vt[v].exp, cyc);
      if (vt[v].idx == 1) check("repeated polls", 128'((poll_reads[1] - p0) > 1), 128'd1);
    end

    // Grant withheld 50 cycles, a second start ignored, grant dropped for 5 cycles in the wait
    fork
      run_txn(0, 64'd9, 16'h0400, 50, 20, 128'd362880, cyc);
      begin
        repeat (10) @(negedge clk);
        start[0]   = 1'b1;
        operand[0] = 64'd7;
        @(posedge clk);
        #1 start[0] = 1'b0;
        k = 0;
        while (!(m_req[0] && m_grant[0] && m_addr[0] == 16'h7010) && k < 500) begin
          @(negedge clk);
          k++;
        end
        check("reached wait", 128'(k < 500), 128'd1);
        gnt_block[0] = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("m_req held", 128'(m_req[0]), 128'd1);
          check("frozen m_wr", 128'(m_wr[0]), 128'd0);
        end
        gnt_block[0] = 1'b0;
      end
    join

    // Interrupt tied low: 64 wait cycles, then 7008 <- 1, 0 and an error pulse
    intr_kill[0] = 1'b1;
    gnt_delay[0] = 0;
    acc_lat[0]   = 2;
    r0 = result[0];
    e0 = err_cnt[0];
    d0 = done_cnt[0];
    wlog.delete();
    launch(0, 64'd4, 16'h0500);
    wait_end(0, cyc, gdn, ger);
    check("timeout error", 128'(ger), 128'd1);
    check("timeout no done", 128'(gdn), 128'd0);
    check("timeout latency", 128'(cyc), 128'd72);
    check("timeout result kept", result[0], r0);
    ea = '{16'h7020, 16'h7018, 16'h7000, 16'h7008, 16'h7008, 16'h0, 16'h0};
    ed = '{64'd4, 64'd1, 64'd1, 64'd1, 64'd0, 64'd0, 64'd0};
    check_log(5, ea, ed);
    @(negedge clk);
    check("timeout busy", 128'(busy[0]), 128'd0);
    check("timeout m_req", 128'(m_req[0]), 128'd0);
    check("error pulses", 128'(err_cnt[0] - e0), 128'd1);
    check("timeout done pulses", 128'(done_cnt[0] - d0), 128'd0);
    intr_kill[0] = 1'b0;

    // Reset while reading the high result word, then a clean run
    acc_lat[0] = 3;
    launch(0, 64'd11, 16'h0600);
    k = 0;
    while (!(m_req[0] && m_addr[0] == 16'h7028) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reached R_RESH", 128'(k < 500), 128'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid rst m_req", 128'(m_req[0]), 128'd0);
    check("mid rst m_wr", 128'(m_wr[0]), 128'd0);
    check("mid rst m_addr", 128'(m_addr[0]), 128'd0);
    check("mid rst m_dout", 128'(m_dout[0]), 128'd0);
    check("mid rst busy", 128'(busy[0]), 128'd0);
    check("mid rst result", result[0], 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(0, 64'd6, 16'h0610, 0, 3, 128'd720, cyc);

    for (int i = 0; i < 2; i++) begin
      check("access without grant", 128'(nogrant_viol[i]), 128'd0);
      check("early m_req drop", 128'(early_drop[i]), 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
